// File: rtl/seq_mant_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_mant_multiplier: iterative shift-and-add unsigned mantissa multiplier |
// | with a carry-select accumulator adder.            Rev 1.0                 |
// +--------------------------------------------------------------------------+

module csel_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module csel_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] sum0;
  logic [W-1:0] sum1;
  logic         co0;
  logic         co1;

  csel_rca #(.W(W)) u_rca0 (.a(a), .b(b), .cin(1'b0), .sum(sum0), .cout(co0));
  csel_rca #(.W(W)) u_rca1 (.a(a), .b(b), .cin(1'b1), .sum(sum1), .cout(co1));

  // Both speculative results are ready before the incoming carry settles.
  assign sum  = cin ? sum1 : sum0;
  assign cout = cin ? co1 : co0;
endmodule

module csel_adder #(
  parameter int N   = 24,
  parameter int BLK = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int NB = N / BLK;

  generate
    for (genvar k = 0; k < NB; k++) begin : g_blk
      logic co;
      if (k == 0) begin : g_first
        csel_rca #(.W(BLK)) u_rca (
          .a    (a[BLK-1:0]),
          .b    (b[BLK-1:0]),
          .cin  (1'b0),
          .sum  (sum[BLK-1:0]),
          .cout (co)
        );
      end else begin : g_rest
        csel_block #(.W(BLK)) u_blk (
          .a    (a[k*BLK +: BLK]),
          .b    (b[k*BLK +: BLK]),
          .cin  (g_blk[k-1].co),
          .sum  (sum[k*BLK +: BLK]),
          .cout (co)
        );
      end
    end
  endgenerate

  assign cout = g_blk[NB-1].co;
endmodule

module seq_mant_multiplier #(
  parameter int N   = 24,
  parameter int BLK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p_o
);
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (N % BLK != 0) begin : g_bad_blk
      $error("seq_mant_multiplier: N must be a multiple of BLK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;

  logic [N-1:0]  addend;
  logic [N-1:0]  add_sum;
  logic          add_co;
  logic [N-1:0]  next_acc;
  logic [N-1:0]  next_mplier;

  assign addend = mplier[0] ? mcand : '0;

  csel_adder #(.N(N), .BLK(BLK)) u_add (
    .a    (acc),
    .b    (addend),
    .sum  (add_sum),
    .cout (add_co)
  );

  // {c,s,mplier} >> 1: the carry enters the accumulator top, the sum LSB enters the multiplier.
  assign next_acc    = {add_co, add_sum[N-1:1]};
  assign next_mplier = {add_sum[0], mplier[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p_o       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a_i;
            mplier   <= b_i;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= next_acc;
          mplier <= next_mplier;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            p_o       <= {next_acc, next_mplier};
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire
